// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_pkg : shared types and defaults for the bus address decoder             |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CONNECT = 2'd2
  } dec_state_t;

  localparam int DEFAULT_NUM_SLAVES = 3;
  localparam int DEFAULT_SEL_WIDTH  = 2;

  typedef logic [DEFAULT_SEL_WIDTH-1:0] dev_id_t;

endpackage
`default_nettype wire

// File: rtl/bus_slave_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_slave_mux : combinational sel-indexed fan-out/fan-in of slave lines     |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module bus_slave_mux
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEFAULT_NUM_SLAVES,
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
  input  logic                  en_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  m_master_valid_i,
  input  logic                  m_master_ready_i,
  output logic                  m_rd_bus_o,
  output logic                  m_slave_valid_o,
  output logic                  m_slave_ready_o,
  output logic [NUM_SLAVES-1:0] s_master_valid_o,
  output logic [NUM_SLAVES-1:0] s_master_ready_o,
  input  logic [NUM_SLAVES-1:0] s_rd_bus_i,
  input  logic [NUM_SLAVES-1:0] s_slave_valid_i,
  input  logic [NUM_SLAVES-1:0] s_slave_ready_i
);

  logic [NUM_SLAVES-1:0] w_hit;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_hit
    assign w_hit[g] = en_i && (sel_i == SEL_WIDTH'(g));
  end

  assign s_master_valid_o = w_hit & {NUM_SLAVES{m_master_valid_i}};
  assign s_master_ready_o = w_hit & {NUM_SLAVES{m_master_ready_i}};

  // w_hit is one-hot or zero, so an AND-OR reduction is the read-back mux
  assign m_rd_bus_o      = |(w_hit & s_rd_bus_i);
  assign m_slave_valid_o = |(w_hit & s_slave_valid_i);
  assign m_slave_ready_o = |(w_hit & s_slave_ready_i);

endmodule
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_addr_decoder : serial device-select decode and slave-port routing       |
// | Optional idle watchdog enabled by defining DECODER_TIMEOUT_EN.              |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES     = DEFAULT_NUM_SLAVES,
  parameter int SEL_WIDTH      = DEFAULT_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bgrant,
  input  logic                  m_mode,
  input  logic                  m_wr_bus,
  input  logic                  m_master_valid,
  input  logic                  m_master_ready,
  output logic                  m_rd_bus,
  output logic                  m_slave_valid,
  output logic                  m_slave_ready,
  output logic                  ack,
  output logic                  s_mode,
  output logic                  s_wr_bus,
  output logic [NUM_SLAVES-1:0] s_master_valid,
  output logic [NUM_SLAVES-1:0] s_master_ready,
  input  logic [NUM_SLAVES-1:0] s_rd_bus,
  input  logic [NUM_SLAVES-1:0] s_slave_valid,
  input  logic [NUM_SLAVES-1:0] s_slave_ready,
  output logic                  timeout
);

  localparam int               CNT_W      = $clog2(SEL_WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(SEL_WIDTH - 1);

  if (NUM_SLAVES < 1 || NUM_SLAVES > (1 << SEL_WIDTH) || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("bus_addr_decoder: illegal NUM_SLAVES/SEL_WIDTH/TIMEOUT_CYCLES");
  end

  dec_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_sr_q, sel_sr_d;
  logic [SEL_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 ack_q, ack_d;
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] w_sel_next;
  logic                 w_sel_valid;
  logic                 w_conn_en;
  logic                 w_mux_ready;

  assign w_sel_next  = SEL_WIDTH'({sel_sr_q, m_wr_bus});
  assign w_sel_valid = (int'(w_sel_next) < NUM_SLAVES);
  assign w_conn_en   = (state_q == CONNECT) && bgrant;

  assign s_mode        = m_mode;
  assign s_wr_bus      = m_wr_bus;
  assign ack           = ack_q;
  assign m_slave_ready = ((state_q == ADDR) && bgrant) || w_mux_ready;

  bus_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .en_i             (w_conn_en),
    .sel_i            (id_q),
    .m_master_valid_i (m_master_valid),
    .m_master_ready_i (m_master_ready),
    .m_rd_bus_o       (m_rd_bus),
    .m_slave_valid_o  (m_slave_valid),
    .m_slave_ready_o  (w_mux_ready),
    .s_master_valid_o (s_master_valid),
    .s_master_ready_o (s_master_ready),
    .s_rd_bus_i       (s_rd_bus),
    .s_slave_valid_i  (s_slave_valid),
    .s_slave_ready_i  (s_slave_ready)
  );

`ifdef DECODER_TIMEOUT_EN
  localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sel_sr_q  <= '0;
      id_q      <= '0;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_sr_q  <= sel_sr_d;
      id_q      <= id_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      lock_q    <= lock_d;
    end
  end

  // lock_q holds off re-entry to ADDR after a rejected id or a watchdog drop
  // until the arbiter has withdrawn the grant at least once.
  always_comb begin
    state_d   = state_q;
    sel_sr_d  = sel_sr_q;
    id_d      = id_q;
    bit_cnt_d = bit_cnt_q;
    ack_d     = 1'b0;
    lock_d    = lock_q && bgrant;
`ifdef DECODER_TIMEOUT_EN
    to_cnt_d  = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bgrant && !lock_q) begin
          state_d   = ADDR;
          sel_sr_d  = '0;
          bit_cnt_d = '0;
        end
      end
      ADDR: begin
        if (!bgrant) begin
          state_d   = IDLE;
          sel_sr_d  = '0;
          bit_cnt_d = '0;
          id_d      = '0;
        end else if (m_master_valid) begin
          sel_sr_d  = w_sel_next;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == C_LAST_BIT) begin
            if (w_sel_valid) begin
              state_d = CONNECT;
              id_d    = w_sel_next;
              ack_d   = 1'b1;
            end else begin
              state_d = IDLE;
              lock_d  = 1'b1;
            end
          end
        end
      end
      CONNECT: begin
        if (!bgrant) begin
          state_d   = IDLE;
          sel_sr_d  = '0;
          bit_cnt_d = '0;
          id_d      = '0;
        end
`ifdef DECODER_TIMEOUT_EN
        else if (!m_master_valid && !m_slave_valid && !ack_q) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == C_TO_LIMIT) begin
            state_d   = IDLE;
            id_d      = '0;
            lock_d    = 1'b1;
            timeout_d = 1'b1;
            to_cnt_d  = '0;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_addr_decoder : directed vector table, corner sequences, random run   |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_bus_addr_decoder;
  import bus_pkg::*;

  localparam int NS = DEFAULT_NUM_SLAVES;
  localparam int SW = DEFAULT_SEL_WIDTH;
  localparam int OW = 2 * NS + 7;
`ifdef DECODER_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk = 1'b0, rstn = 1'b0, bgrant = 1'b0, m_mode = 1'b0, m_wr_bus = 1'b0;
  logic          m_master_valid = 1'b0, m_master_ready = 1'b0;
  logic [NS-1:0] s_rd_bus = '0, s_slave_valid = '0, s_slave_ready = '0;
  logic          m_rd_bus, m_slave_valid, m_slave_ready, ack, s_mode, s_wr_bus, timeout;
  logic [NS-1:0] s_master_valid, s_master_ready;
  logic [OW-1:0] obs;

  always #5 clk = ~clk;

  bus_addr_decoder #(.NUM_SLAVES(NS), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .bgrant(bgrant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_rd_bus(m_rd_bus), .m_slave_valid(m_slave_valid), .m_slave_ready(m_slave_ready),
    .ack(ack), .s_mode(s_mode), .s_wr_bus(s_wr_bus),
    .s_master_valid(s_master_valid), .s_master_ready(s_master_ready),
    .s_rd_bus(s_rd_bus), .s_slave_valid(s_slave_valid), .s_slave_ready(s_slave_ready),
    .timeout(timeout)
  );

  assign obs = {ack, timeout, s_master_valid, s_master_ready,
                m_rd_bus, m_slave_valid, m_slave_ready, s_mode, s_wr_bus};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (ack,to,smv,smr,mrd,msv,msr,smode,swr)",
                  name, got, exp);
  endtask

  function automatic logic [OW-1:0] expv(input logic eack, eto, input logic [NS-1:0] esmv, esmr,
                                         input logic emrd, emsv, emsr);
    return {eack, eto, esmv, esmr, emrd, emsv, emsr, m_mode, m_wr_bus};
  endfunction

  task automatic drive(input logic bg, mv, wr, mr, input logic [NS-1:0] srd, ssv, ssr);
    @(negedge clk);
    bgrant = bg; m_master_valid = mv; m_wr_bus = wr; m_mode = mv ^ wr; m_master_ready = mr;
    s_rd_bus = srd; s_slave_valid = ssv; s_slave_ready = ssr;
    #1;
  endtask

  typedef struct {
    logic          bg, mv, wr, mr;
    logic [NS-1:0] srd, ssv, ssr;
    logic          eack;
    logic [NS-1:0] esmv, esmr;
    logic          emrd, emsv, emsr;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic bg, mv, wr, mr, input logic [NS-1:0] srd, ssv, ssr,
                     input logic eack, input logic [NS-1:0] esmv, esmr,
                     input logic emrd, emsv, emsr);
    vec_t v;
    v.bg = bg; v.mv = mv; v.wr = wr; v.mr = mr; v.srd = srd; v.ssv = ssv; v.ssr = ssr;
    v.eack = eack; v.esmv = esmv; v.esmr = esmr; v.emrd = emrd; v.emsv = emsv; v.emsr = emsr;
    tv.push_back(v);
  endtask

  // Reference model: the select field as a list of received bits, the live
  // connection as a slave number (-1 when none).
  int m_conn = -1;
  bit m_collect, m_locked, m_ack, m_to;
  int m_bits[$];
  int m_idle;

  task automatic model_reset();
    m_conn = -1; m_collect = 0; m_locked = 0; m_ack = 0; m_to = 0; m_idle = 0;
    m_bits.delete();
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [NS-1:0] smv = '0, smr = '0;
    logic          mrd = 1'b0, msv = 1'b0, msr = 1'b0;
    if (bgrant && m_conn >= 0) begin
      smv[m_conn] = m_master_valid;
      smr[m_conn] = m_master_ready;
      mrd = s_rd_bus[m_conn];
      msv = s_slave_valid[m_conn];
      msr = s_slave_ready[m_conn];
    end else if (bgrant && m_collect) begin
      msr = 1'b1;
    end
    return {m_ack, m_to, smv, smr, mrd, msv, msr, m_mode, m_wr_bus};
  endfunction

  task automatic model_step();
    bit ack_now = m_ack;
    m_ack = 0;
    m_to  = 0;
    if (!bgrant) begin
      m_conn = -1; m_collect = 0; m_locked = 0; m_idle = 0;
      m_bits.delete();
    end else if (m_conn >= 0) begin
      if (TO_ON) begin
        if (!m_master_valid && !s_slave_valid[m_conn] && !ack_now) m_idle++;
        else m_idle = 0;
        if (m_idle == TO) begin
          m_conn = -1; m_locked = 1; m_to = 1; m_idle = 0;
        end
      end
    end else if (m_collect) begin
      if (m_master_valid) begin
        m_bits.push_back(int'(m_wr_bus));
        if (m_bits.size() == SW) begin
          int id = 0;
          foreach (m_bits[i]) id = id * 2 + m_bits[i];
          m_collect = 0;
          m_bits.delete();
          if (id < NS) begin
            m_conn = id; m_ack = 1; m_idle = 0;
          end else begin
            m_locked = 1;
          end
        end
      end
    end else if (!m_locked) begin
      m_collect = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //   bg mv wr mr srd     ssv     ssr     | ack smv     smr     mrd msv msr
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 1, 3'b100, 3'b100, 3'b000,  1, 3'b100, 3'b100, 1, 1, 0);
    add(1, 0, 0, 1, 3'b011, 3'b100, 3'b000,  0, 3'b000, 3'b100, 0, 1, 0);
    add(1, 1, 0, 0, 3'b100, 3'b000, 3'b100,  0, 3'b100, 3'b000, 1, 0, 1);
    add(0, 1, 0, 1, 3'b111, 3'b111, 3'b111,  0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    // select 01 with a two-cycle stall carrying a stray 1 on the write line
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 0, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 0, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 0, 3'b010, 3'b000, 3'b000,  1, 3'b010, 3'b000, 1, 0, 0);
    add(1, 1, 0, 1, 3'b101, 3'b010, 3'b010,  0, 3'b010, 3'b010, 0, 1, 1);
    // invalid select 11, locked out until the grant toggles, then select 00
    add(0, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 1, 3'b111, 3'b111, 3'b111,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 1, 3'b001, 3'b001, 3'b001,  1, 3'b001, 3'b001, 1, 1, 1);
    // grant lost after one select bit, then a fresh select 10
    add(0, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(0, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(1, 0, 0, 0, 3'b100, 3'b000, 3'b100,  1, 3'b000, 3'b000, 1, 0, 1);
    // last select bit coincides with grant loss: no connection, no ack
    add(0, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 1);
    add(0, 1, 1, 0, 3'b000, 3'b000, 3'b000,  0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 1, 0, 1, 3'b010, 3'b010, 3'b010,  0, 3'b000, 3'b000, 0, 0, 0);
    add(1, 1, 0, 1, 3'b010, 3'b010, 3'b010,  0, 3'b000, 3'b000, 0, 0, 0);

    // reset state, including an active clock edge with the grant raised
    #2;
    check("reset_state", obs, '0);
    bgrant = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold", obs, '0);
    bgrant = 1'b0;
    rstn   = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].bg, tv[i].mv, tv[i].wr, tv[i].mr, tv[i].srd, tv[i].ssv, tv[i].ssr);
      check($sformatf("vec%0d", i), obs,
            expv(tv[i].eack, 1'b0, tv[i].esmv, tv[i].esmr, tv[i].emrd, tv[i].emsv, tv[i].emsr));
    end

    // asynchronous reset while connected to slave 0
    drive(1, 1, 0, 0, '0, '0, '0);
    check("ar_addr", obs, expv(0, 0, '0, '0, 0, 0, 1));
    drive(1, 1, 0, 0, '0, '0, '0);
    drive(1, 1, 0, 1, 3'b001, 3'b001, 3'b001);
    check("ar_conn", obs, expv(1, 0, 3'b001, 3'b001, 1, 1, 1));
    #2 rstn = 1'b0;
    #1 check("ar_async", obs, expv(0, 0, '0, '0, 0, 0, 0));
    drive(1, 1, 0, 1, 3'b001, 3'b001, 3'b001);
    rstn = 1'b1;
    check("ar_idle", obs, expv(0, 0, '0, '0, 0, 0, 0));
    drive(1, 0, 0, 0, 3'b001, 3'b001, 3'b001);
    check("ar_regrant", obs, expv(0, 0, '0, '0, 0, 0, 1));

`ifdef DECODER_TIMEOUT_EN
    drive(1, 1, 0, 1, '0, '0, '0);
    drive(1, 1, 1, 1, '0, '0, '0);
    drive(1, 0, 0, 1, '0, '0, '0);
    check("to_ack", obs, expv(1, 0, '0, 3'b010, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 1, '0, '0, '0);
      check("to_idle_a", obs, expv(0, 0, '0, 3'b010, 0, 0, 0));
    end
    drive(1, 1, 0, 1, '0, '0, '0);
    check("to_activity", obs, expv(0, 0, 3'b010, 3'b010, 0, 0, 0));
    for (int k = 0; k < TO; k++) begin
      drive(1, 0, 0, 1, '0, '0, '0);
      check("to_idle_b", obs, expv(0, 0, '0, 3'b010, 0, 0, 0));
    end
    drive(1, 0, 0, 1, '0, '0, '0);
    check("to_pulse", obs, expv(0, 1, '0, '0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, '0, '0, '0);
      check("to_locked", obs, expv(0, 0, '0, '0, 0, 0, 0));
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    check("to_regrant", obs, expv(0, 0, '0, '0, 0, 0, 1));
`endif

    // randomized run against the reference model
    @(negedge clk);
    rstn = 1'b0;
    bgrant = 1'b0; m_master_valid = 1'b0; m_master_ready = 1'b0; m_wr_bus = 1'b0; m_mode = 1'b0;
    s_rd_bus = '0; s_slave_valid = '0; s_slave_ready = '0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) bgrant = ~bgrant;
      m_master_valid = ($urandom_range(0, 99) < 45);
      m_master_ready = ($urandom_range(0, 99) < 50);
      m_wr_bus       = ($urandom_range(0, 1) == 1);
      m_mode         = ($urandom_range(0, 1) == 1);
      s_rd_bus       = NS'($urandom());
      s_slave_valid  = NS'($urandom()) & NS'($urandom());
      s_slave_ready  = NS'($urandom());
      #1;
      check("random", obs, model_out());
      @(posedge clk);
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
- Sits downstream of the arbiter and the granted master port, and upstream of the slave ports.
- Deserialises the device-select field that the granted master shifts out first on its serial write line.
- Then connects the master's serial handshake lines to exactly one slave port until the arbiter withdraws the grant.
- Also muxes the selected slave's serial read line and handshake signals back to the master.

Parameters:
- NUM_SLAVES, 3, number of attached slave ports (valid device ids are 0..NUM_SLAVES-1).
- SEL_WIDTH, 2, width of the device-select field; it is received MSB first.
- TIMEOUT_CYCLES, 255, idle-cycle limit used only when DECODER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- bgrant  in  1  arbiter grant; high while the bus is owned by a master
- m_mode  in  1  master transfer mode (0 read, 1 write)
- m_wr_bus  in  1  master serial write data
- m_master_valid  in  1  master data valid
- m_master_ready  in  1  master ready to accept read data
- m_rd_bus  out  1  serial read data to the master
- m_slave_valid  out  1  selected slave read-data valid
- m_slave_ready  out  1  decoder/slave ready to accept master data
- ack  out  1  one-cycle pulse: valid device selected
- s_mode  out  1  mode broadcast to the slaves
- s_wr_bus  out  1  serial write data broadcast to the slaves
- s_master_valid  out  NUM_SLAVES  per-slave master valid
- s_master_ready  out  NUM_SLAVES  per-slave master ready
- s_rd_bus  in  NUM_SLAVES  per-slave serial read data
- s_slave_valid  in  NUM_SLAVES  per-slave read-data valid
- s_slave_ready  in  NUM_SLAVES  per-slave ready
- timeout  out  1  one-cycle pulse: connection dropped by the watchdog

Clock/reset: one clock, clk; reset rstn is asynchronous, active-low.

Behaviour:
- Reset:
  - State goes to IDLE; the select shift register, bit counter and selected id all clear to 0.
  - All outputs are 0.
- Data outputs (s_mode, s_wr_bus): these are plain fan-out of m_mode and m_wr_bus in every state. Slaves ignore them unless their own s_master_valid bit is high.
- States: IDLE, ADDR, CONNECT.
- IDLE:
  - All master-side outputs are 0 and all s_master_valid/s_master_ready bits are 0.
  - Moves to ADDR on the first cycle bgrant=1.
- ADDR:
  - m_slave_ready=1.
  - Each cycle with m_master_valid=1, shift m_wr_bus into the select register (MSB first) and increment the bit counter.
  - Cycles with m_master_valid=0 are stalls: no shift, no count.
  - On the cycle the SEL_WIDTH-th bit is accepted:
    - if the id is < NUM_SLAVES, latch it and go to CONNECT;
    - otherwise go to IDLE, with no ack and no slave strobe.
    - In the invalid case the decoder then stays in IDLE until bgrant falls and rises again.
- CONNECT (sel = latched id):
  - ack=1 on the first CONNECT cycle only.
  - s_master_valid[sel]=m_master_valid and s_master_ready[sel]=m_master_ready; all other bits are 0.
  - m_rd_bus, m_slave_valid and m_slave_ready are taken combinationally from s_rd_bus[sel], s_slave_valid[sel] and s_slave_ready[sel].
  - Path latency through the decoder is zero cycles.
- bgrant=0 in ADDR or CONNECT:
  - Next state is IDLE; the counter and id clear.
  - Combinational routing is gated by bgrant, so strobes drop in the same cycle.
- A mid-frame grant loss discards the partial select field.
- Simultaneous last select bit and bgrant=0: the grant loss wins, giving IDLE and no ack.
- The bit counter is $clog2(SEL_WIDTH+1) bits wide and never wraps; it resets to 0 on every ADDR entry.
- Async reset mid-transfer forces IDLE immediately; all strobes go to 0 without waiting for a clock edge.

Optional Feature:
- Macro: DECODER_TIMEOUT_EN.
- Defined:
  - In CONNECT, a counter of width $clog2(TIMEOUT_CYCLES+1) increments on each cycle where m_master_valid, s_slave_valid[sel] and ack are all 0.
  - The counter clears on any activity.
  - On reaching TIMEOUT_CYCLES: timeout pulses for 1 cycle, the state goes to IDLE, and all strobes drop on the next cycle.
  - The decoder stays in IDLE until bgrant falls and rises again, so the master port / arbiter must release.
- Undefined: the timeout output is tied to 0 and no counter logic is present.

Decomposition:
- Shared package bus_pkg holds:
  - the state enum dec_state_t {IDLE, ADDR, CONNECT};
  - the constants DEFAULT_NUM_SLAVES=3 and DEFAULT_SEL_WIDTH=2;
  - the device-id type.
- One sub-module is natural: bus_slave_mux, the purely combinational sel-indexed fan-out/fan-in of the handshake and data lines.
- The FSM, shift register, counters and watchdog stay in bus_addr_decoder.

Test Plan:
- bgrant=1, shift bits 1,0 with m_master_valid=1 on consecutive cycles:
  - ack high on the cycle after the 2nd bit;
  - s_master_valid=3'b100 follows m_master_valid;
  - m_rd_bus follows s_rd_bus[2].
- Select 01 with a 2-cycle m_master_valid=0 stall between bits: no shift during the stall; connects to slave 1 with exactly one ack pulse.
- Select 11 with NUM_SLAVES=3: no ack; s_master_valid stays 000; remains IDLE while bgrant is held; reconnects after a bgrant 0→1 and select 00.
- bgrant drops after the 1st select bit, then a new grant delivers select 10: the partial bit is discarded; connects to slave 2.
- In CONNECT to slave 0, rstn pulsed low asynchronously mid-cycle: all outputs 0 before the next clk edge; state IDLE.
- With DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=8, connected with no activity for 8 cycles: timeout pulses once; strobes drop; no reconnect until bgrant toggles. Activity at cycle 7 restarts the count.
